freq_calc_ctrl: RTL



---
 rtl/freq_calc_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/freq_calc_ctrl.sv
// Arms the period counter, captures the period in ms and converts it to
// a frequency in mHz with a sequential restoring divider.
module freq_calc_ctrl #(
  parameter int DIVIDEND = 1000000,
  parameter int PRD_W    = 10,
  parameter int Q_W      = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  output logic             done_tick,
  output logic             err,
  output logic [Q_W-1:0]   freq,
  output logic             pc_start,
  input  logic             pc_ready,
  input  logic             pc_done_tick,
  input  logic [PRD_W-1:0] pc_prd
);

  localparam int CNT_W = $clog2(Q_W + 1);
  localparam logic [Q_W-1:0] DVD_INIT = Q_W'(DIVIDEND);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(Q_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_MEAS,
    S_DIV,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [PRD_W-1:0] dvsr;
  logic [PRD_W:0]   rem;
  logic [Q_W-1:0]   dvd;
  logic [CNT_W-1:0] cnt;

  logic [PRD_W:0]   trial;
  logic [PRD_W:0]   diff;
  logic             ge;
  logic [PRD_W:0]   rem_nxt;
  logic [Q_W-1:0]   dvd_nxt;
  logic             last;

  logic             load;
  logic             zero_prd;
  logic             step;

  // Quotient bits shift into the dividend register as its MSBs shift out.
  always_comb begin
    trial   = {rem[PRD_W-1:0], dvd[Q_W-1]};
    diff    = trial - {1'b0, dvsr};
    ge      = (trial >= {1'b0, dvsr});
    rem_nxt = ge ? diff : trial;
    dvd_nxt = {dvd[Q_W-2:0], ge};
    last    = (cnt == CNT_W'(1));
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    pc_start  = 1'b0;
    done_tick = 1'b0;
    load      = 1'b0;
    zero_prd  = 1'b0;
    step      = 1'b0;
    unique case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = S_ARM;
      end
      S_ARM: begin
        if (pc_ready) begin
          pc_start  = !reset;
          state_nxt = S_MEAS;
        end
      end
      S_MEAS: begin
        if (pc_done_tick) begin
          if (pc_prd == '0) begin
            zero_prd  = 1'b1;
            state_nxt = S_DONE;
          end else begin
            load      = 1'b1;
            state_nxt = S_DIV;
          end
        end
      end
      S_DIV: begin
        step = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done_tick = !reset;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      freq <= '0;
      err  <= 1'b0;
      dvsr <= '0;
      rem  <= '0;
      dvd  <= '0;
      cnt  <= '0;
    end else if (zero_prd) begin
      freq <= '1;
      err  <= 1'b1;
    end else if (load) begin
      err  <= 1'b0;
      dvsr <= pc_prd;
      rem  <= '0;
      dvd  <= DVD_INIT;
      cnt  <= CNT_INIT;
    end else if (step) begin
      rem <= rem_nxt;
      dvd <= dvd_nxt;
      cnt <= cnt - CNT_W'(1);
      if (last) freq <= dvd_nxt;
    end
  end

endmodule
